// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Conditions the raw alarm inputs for the downstream alarm FSM.
//   - temp_raw / humo_raw: two-flop synchronizer followed by a debouncer.
//     A flag only changes after DB_CYCLES consecutive cycles of disagreement.
//   - adc_valid / adc_data / adc_ready: accepts 2**AVG_LOG2 unsigned 8-bit
//     samples and publishes the top N bits of their mean on corriente.
//     corriente_valid pulses for one cycle on each update.
//   - sensor_fault: ADC watchdog. It is present only when the macro
//     SENSOR_WATCHDOG_EN is defined, and is tied to 0 otherwise.
//     On expiry, corriente is forced to all ones as a fail-safe value.
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-low reset
//   temp_raw        in   raw over-temperature contact (asynchronous)
//   humo_raw        in   raw smoke contact (asynchronous)
//   adc_valid       in   ADC sample present
//   adc_data[7:0]   in   ADC sample
//   adc_ready       out  sample accepted when adc_valid is also high
//   temp, humo      out  debounced flags
//   corriente[N-1:0] out averaged current code
//   corriente_valid out  one-cycle update strobe
//   sensor_fault    out  watchdog expired
module sensor_conditioner #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16,
    parameter int AVG_LOG2  = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         temp_raw,
    input  logic         humo_raw,
    input  logic         adc_valid,
    input  logic [7:0]   adc_data,
    output logic         adc_ready,
    output logic         temp,
    output logic         humo,
    output logic [N-1:0] corriente,
    output logic         corriente_valid,
    output logic         sensor_fault
);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("sensor_conditioner: N must be in 1..8");
    end
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("sensor_conditioner: DB_CYCLES must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("sensor_conditioner: TIMEOUT must be at least 2");
    end

    localparam int DBW  = $clog2(DB_CYCLES);
    localparam int ACCW = 8 + AVG_LOG2;
    localparam int CNTW = AVG_LOG2 + 1;
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [CNTW-1:0] SMP_LAST = CNTW'((2 ** AVG_LOG2) - 1);

    // ---------------- synchronizers and debouncers (bit0 temp, bit1 humo)
    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_flag;
    logic [DBW-1:0] r_db_cnt [2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_flag  <= '0;
            for (int unsigned i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= {humo_raw, temp_raw};
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_flag[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_flag[i]   <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign temp = r_flag[0];
    assign humo = r_flag[1];

    // ---------------- ADC averaging FSM
    typedef enum logic {ST_ACCUM, ST_LOAD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;       // low during reset and for the first edge after it
    logic            w_ready;
    logic            w_load;
    logic            w_accept;
    logic [ACCW-1:0] r_acc;
    logic [CNTW-1:0] r_cnt;
    logic [N-1:0]    r_corr;
    logic [N-1:0]    w_corr_nxt;
    logic            r_cv;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_ACCUM;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && r_cnt == SMP_LAST) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_ACCUM;
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    always_comb begin
        w_ready = r_run && (r_state == ST_ACCUM);
        w_load  = (r_state == ST_LOAD);
    end

    assign w_accept = adc_valid && w_ready;
    // Mean is sum >> AVG_LOG2 (fits 8 bits); keep its top N bits.
    assign w_corr_nxt = N'(r_acc >> (AVG_LOG2 + 8 - N));

`ifdef SENSOR_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] r_wd;
    logic           r_fault;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_corr <= '0;
            r_cv   <= 1'b0;
`ifdef SENSOR_WATCHDOG_EN
            r_wd    <= '0;
            r_fault <= 1'b0;
`endif
        end else begin
            r_cv <= 1'b0;
            if (w_load) begin
                r_corr <= w_corr_nxt;
                r_cv   <= 1'b1;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else if (w_accept) begin
                r_acc <= r_acc + ACCW'(adc_data);
                r_cnt <= r_cnt + CNTW'(1);
            end
`ifdef SENSOR_WATCHDOG_EN
            // An acceptance on the expiry edge takes priority over the fault.
            // The counter parks at its last value, so the force repeats until a sample arrives.
            if (w_accept) begin
                r_wd    <= '0;
                r_fault <= 1'b0;
            end else if (r_wd == WD_LAST) begin
                r_fault <= 1'b1;
                r_corr  <= '1;
            end else begin
                r_wd <= r_wd + WDW'(1);
            end
`endif
        end
    end

    assign adc_ready       = w_ready;
    assign corriente       = r_corr;
    assign corriente_valid = r_cv;
`ifdef SENSOR_WATCHDOG_EN
    assign sensor_fault    = r_fault;
`else
    assign sensor_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner.
module tb_sensor_conditioner;
    localparam int N  = 4;
    localparam int DB = 16;
    localparam int AL = 2;
    localparam int TO = 1024;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         temp_raw  = 1'b0;
    logic         humo_raw  = 1'b0;
    logic         adc_valid = 1'b0;
    logic [7:0]   adc_data  = 8'h00;
    logic         adc_ready;
    logic         temp;
    logic         humo;
    logic [N-1:0] corriente;
    logic         corriente_valid;
    logic         sensor_fault;

    int n_tests = 0;
    int n_fail  = 0;

    sensor_conditioner #(
        .N(N), .DB_CYCLES(DB), .AVG_LOG2(AL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .temp_raw(temp_raw), .humo_raw(humo_raw),
        .adc_valid(adc_valid), .adc_data(adc_data), .adc_ready(adc_ready),
        .temp(temp), .humo(humo), .corriente(corriente),
        .corriente_valid(corriente_valid), .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    // ---------------- reference model
    // A flag adopts a value once the synchronized input (raw delayed two
    // edges) has shown it for DB consecutive edges. The ADC path collects
    // 2**AL accepted samples, spends one cycle publishing their mean, and
    // the watchdog fires after TO consecutive edges without acceptance.
    logic [DB+1:0] m_sh_t = '0;
    logic [DB+1:0] m_sh_h = '0;
    logic [DB-1:0] m_win;
    bit            m_temp, m_humo, m_ready, m_load_pending, m_cv, m_fault, m_acc;
    int unsigned   m_samples[$];
    int unsigned   m_sum, m_idle;
    logic [N-1:0]  m_corr = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_sh_t = '0; m_sh_h = '0;
            m_temp = 0; m_humo = 0; m_ready = 0; m_load_pending = 0;
            m_cv = 0; m_fault = 0; m_idle = 0; m_corr = '0;
            m_samples.delete();
        end else begin
            m_sh_t = {m_sh_t[DB:0], temp_raw};
            m_win  = m_sh_t[DB+1:2];
            if (m_win == '1) m_temp = 1; else if (m_win == '0) m_temp = 0;
            m_sh_h = {m_sh_h[DB:0], humo_raw};
            m_win  = m_sh_h[DB+1:2];
            if (m_win == '1) m_humo = 1; else if (m_win == '0) m_humo = 0;

            m_acc = adc_valid && m_ready;
            m_cv  = 0;
            if (m_load_pending) begin
                m_sum = 0;
                foreach (m_samples[i]) m_sum += m_samples[i];
                m_corr = N'((m_sum / (2 ** AL)) >> (8 - N));
                m_cv = 1;
                m_samples.delete();
                m_load_pending = 0;
                m_ready = 1;
            end else begin
                if (m_acc) begin
                    m_samples.push_back(int'(adc_data));
                    if (m_samples.size() == 2 ** AL) m_load_pending = 1;
                end
                m_ready = !m_load_pending;
            end
`ifdef SENSOR_WATCHDOG_EN
            if (m_acc) begin
                m_idle = 0;
                m_fault = 0;
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_fault = 1;
                    m_corr = '1;
                end
            end
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; temp_raw = 0; humo_raw = 0; adc_valid = 0; adc_data = 0;
        repeat (2) tick();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0; temp_raw = 1; humo_raw = 1; adc_valid = 1; adc_data = 8'hFF;
        repeat (3) begin
            tick();
            n_tests++;
            if ({temp, humo, corriente_valid, sensor_fault, adc_ready} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_flags got %b expected 00000",
                         {temp, humo, corriente_valid, sensor_fault, adc_ready});
            end
            n_tests++;
            if (corriente !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_corriente got %h expected 0", corriente);
            end
        end
        reset = 1; temp_raw = 0; humo_raw = 0; adc_valid = 0;
        tick();
        n_tests++;
        if (adc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b expected 1", adc_ready);
        end
    endtask

    task automatic test_temp_edge();
        logic exp;
        do_reset();
        repeat (3) tick();
        temp_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = (i >= 18);
            n_tests++;
            if (temp !== exp) begin
                n_fail++;
                $display("FAIL temp_rise cycle %0d got %b expected %b", i, temp, exp);
            end
            n_tests++;
            if (humo !== 1'b0) begin
                n_fail++;
                $display("FAIL humo_isolation cycle %0d got %b expected 0", i, humo);
            end
        end
        temp_raw = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = (i < 18);
            n_tests++;
            if (temp !== exp) begin
                n_fail++;
                $display("FAIL temp_fall cycle %0d got %b expected %b", i, temp, exp);
            end
        end
    endtask

    task automatic test_humo_bounce();
        logic exp;
        do_reset();
        repeat (3) tick();
        humo_raw = 1;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) humo_raw = 0;
            tick();
            n_tests++;
            if (humo !== 1'b0) begin
                n_fail++;
                $display("FAIL humo_bounce_early cycle %0d got %b expected 0", i, humo);
            end
        end
        humo_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = (i >= 18);
            n_tests++;
            if (humo !== exp) begin
                n_fail++;
                $display("FAIL humo_bounce cycle %0d got %b expected %b", i, humo, exp);
            end
        end
    endtask

    task automatic test_adc_average();
        logic [7:0]   smp [5];
        int           idx, n_pulse, n_low;
        logic         rb;
        logic [N-1:0] seen;
        smp[0] = 8'hC0; smp[1] = 8'hC4; smp[2] = 8'hC8; smp[3] = 8'hCC; smp[4] = 8'h55;
        do_reset();
        tick();
        idx = 0; n_pulse = 0; n_low = 0; seen = '0;
        adc_valid = 1; adc_data = smp[0];
        for (int c = 0; c < 12; c++) begin
            rb = adc_ready;
            tick();
            if (rb && adc_valid) idx++;
            if (idx < 5) adc_data = smp[idx]; else adc_valid = 0;
            if (adc_ready === 1'b0) n_low++;
            if (corriente_valid === 1'b1) begin
                n_pulse++;
                seen = corriente;
            end
        end
        n_tests++;
        if (n_pulse != 1) begin
            n_fail++;
            $display("FAIL avg_pulse_count got %0d expected 1", n_pulse);
        end
        n_tests++;
        if (seen !== 4'hC) begin
            n_fail++;
            $display("FAIL avg_value got %h expected c", seen);
        end
        n_tests++;
        if (n_low != 1) begin
            n_fail++;
            $display("FAIL ready_low_cycles got %0d expected 1", n_low);
        end
        n_tests++;
        if (idx != 5) begin
            n_fail++;
            $display("FAIL pending_sample_accepted got %0d expected 5", idx);
        end
        repeat (4) tick();
        n_tests++;
        if (corriente !== 4'hC) begin
            n_fail++;
            $display("FAIL avg_hold got %h expected c", corriente);
        end
    endtask

    task automatic test_reset_mid_accum();
        int           cnt, guard, n_pulse;
        logic         rb;
        logic [N-1:0] seen;
        do_reset();
        cnt = 0; guard = 0; n_pulse = 0; seen = '0;
        adc_valid = 1; adc_data = 8'hFF;
        while (cnt < 3 && guard < 10) begin
            rb = adc_ready;
            tick();
            guard++;
            if (rb) cnt++;
            if (corriente_valid === 1'b1) n_pulse++;
        end
        adc_valid = 0; reset = 0;
        tick();
        reset = 1;
        n_tests++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL prereset_accepts got %0d expected 3", cnt);
        end
        cnt = 0; guard = 0;
        adc_valid = 1; adc_data = 8'h10;
        while (cnt < 4 && guard < 20) begin
            rb = adc_ready;
            tick();
            guard++;
            if (rb) cnt++;
            if (cnt == 4) adc_valid = 0;
            if (corriente_valid === 1'b1) n_pulse++;
        end
        repeat (3) begin
            tick();
            if (corriente_valid === 1'b1) begin
                n_pulse++;
                seen = corriente;
            end
        end
        n_tests++;
        if (n_pulse != 1) begin
            n_fail++;
            $display("FAIL reset_mid_pulses got %0d expected 1", n_pulse);
        end
        n_tests++;
        if (seen !== 4'h1) begin
            n_fail++;
            $display("FAIL reset_mid_value got %h expected 1", seen);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, ((c / 100) % 2 == 1) ? 2 : 24) == 0) temp_raw = ~temp_raw;
            if ($urandom_range(0, ((c / 75) % 2 == 1) ? 3 : 20) == 0) humo_raw = ~humo_raw;
            adc_valid = ($urandom_range(0, 3) != 0);
            adc_data  = 8'($urandom);
            tick();
            n_tests++;
            if ({temp, humo} !== {m_temp, m_humo}) begin
                n_fail++;
                $display("FAIL rand_flags cycle %0d got %b expected %b", c, {temp, humo}, {m_temp, m_humo});
            end
            n_tests++;
            if ({adc_ready, corriente_valid, sensor_fault} !== {m_ready, m_cv, m_fault}) begin
                n_fail++;
                $display("FAIL rand_adc_ctrl cycle %0d got %b expected %b", c,
                         {adc_ready, corriente_valid, sensor_fault}, {m_ready, m_cv, m_fault});
            end
            n_tests++;
            if (corriente !== m_corr) begin
                n_fail++;
                $display("FAIL rand_corriente cycle %0d got %h expected %h", c, corriente, m_corr);
            end
        end
    endtask

    task automatic test_watchdog();
        int           cnt, guard;
        logic         rb, exp_f;
        logic [N-1:0] exp_c;
        do_reset();
        cnt = 0; guard = 0;
        adc_valid = 1; adc_data = 8'h80;
        while (cnt < 4 && guard < 20) begin
            rb = adc_ready;
            tick();
            guard++;
            if (rb) cnt++;
            if (cnt == 4) adc_valid = 0;
        end
        n_tests++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL wd_setup_accepts got %0d expected 4", cnt);
        end
        for (int k = 1; k <= 1030; k++) begin
            tick();
`ifdef SENSOR_WATCHDOG_EN
            exp_f = (k >= TO);
            exp_c = (k >= TO) ? 4'hF : 4'h8;
`else
            exp_f = 1'b0;
            exp_c = 4'h8;
`endif
            n_tests++;
            if (sensor_fault !== exp_f || corriente !== exp_c) begin
                n_fail++;
                $display("FAIL wd_idle tick %0d got fault=%b corr=%h expected fault=%b corr=%h",
                         k, sensor_fault, corriente, exp_f, exp_c);
            end
        end
        adc_valid = 1; adc_data = 8'h20;
        rb = adc_ready;
        tick();
        adc_valid = 0;
`ifdef SENSOR_WATCHDOG_EN
        exp_c = 4'hF;
`else
        exp_c = 4'h8;
`endif
        n_tests++;
        if (rb !== 1'b1 || sensor_fault !== 1'b0 || corriente !== exp_c) begin
            n_fail++;
            $display("FAIL wd_clear got ready=%b fault=%b corr=%h expected ready=1 fault=0 corr=%h",
                     rb, sensor_fault, corriente, exp_c);
        end
        repeat (TO - 1) tick();
        n_tests++;
        if (sensor_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_before_expiry got %b expected 0", sensor_fault);
        end
        adc_valid = 1; adc_data = 8'h30;
        tick();
        adc_valid = 0;
        n_tests++;
        if (sensor_fault !== 1'b0 || corriente !== exp_c) begin
            n_fail++;
            $display("FAIL wd_sample_wins got fault=%b corr=%h expected fault=0 corr=%h",
                     sensor_fault, corriente, exp_c);
        end
        tick();
        n_tests++;
        if (sensor_fault !== m_fault || corriente !== m_corr) begin
            n_fail++;
            $display("FAIL wd_model got fault=%b corr=%h expected fault=%b corr=%h",
                     sensor_fault, corriente, m_fault, m_corr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_temp_edge();
        test_humo_bounce();
        test_adc_average();
        test_reset_mid_accum();
        test_random();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
